traffic_sensor_conditioner: RTL

- Upstream stage of the two-street traffic-light controller.
- Takes raw vehicle-detector inputs for street A and street B and synchronises each to clk.
- Debounces each input and extends its presence with a gap-hold timer, then produces the clean car-present signals a and b that the light FSM samples.
- Also keeps saturating per-street car counts for status readout.

---
 rtl/traffic_pkg.sv | 16 +
 rtl/sensor_channel.sv | 86 ++++++++
 rtl/traffic_sensor_conditioner.sv | 47 ++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the two-street traffic-light subsystem.
// Sensor defaults and the light-state encoding used by the controller.
package traffic_pkg;

  localparam int DEBOUNCE_DEF = 4;
  localparam int GAP_DEF      = 8;
  localparam int CNT_W        = 8;

  typedef enum logic [1:0] {
    GA_RB = 2'b00,
    YA_RB = 2'b01,
    RA_GB = 2'b10,
    RA_YB = 2'b11
  } light_t;

endpackage

// File: rtl/sensor_channel.sv
// One street's detector path: synchroniser, debounce, gap hold
// and saturating arrival counter.
module sensor_channel
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int GAP      = GAP_DEF,
  parameter int CW       = CNT_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          raw,
  input  logic          clr_cnt,
  output logic          present,
  output logic [CW-1:0] cnt
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int GW = (GAP < 1) ? 1 : $clog2(GAP + 1);

  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE - 1);
  localparam logic [GW-1:0] GLOAD = GW'(GAP);
  localparam logic [CW-1:0] CMAX  = '1;

  logic          s1_q, s2_q;
  logic          db_q, db_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise, fall;

  always_comb begin
    db_d   = db_q;
    dcnt_d = dcnt_q;
    if (s2_q == db_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DLAST) begin
      db_d   = s2_q;
      dcnt_d = '0;
    end else begin
      dcnt_d = dcnt_q + DW'(1);
    end

    rise = db_d & ~db_q;
    fall = db_q & ~db_d;

    // Re-arrival while held cancels the hold; db keeps a high.
    gcnt_d = gcnt_q;
    if (fall) begin
      gcnt_d = GLOAD;
    end else if (db_q) begin
      gcnt_d = '0;
    end else if (gcnt_q != '0) begin
      gcnt_d = gcnt_q - GW'(1);
    end

    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = rise ? CW'(1) : '0;
    end else if (rise && (cnt_q != CMAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      db_q   <= 1'b0;
      dcnt_q <= '0;
      gcnt_q <= '0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= raw;
      s2_q   <= s1_q;
      db_q   <= db_d;
      dcnt_q <= dcnt_d;
      gcnt_q <= gcnt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign present = db_q | (gcnt_q != '0);
  assign cnt     = cnt_q;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Clean car-present signals and arrival counts for streets A and B,
// feeding the traffic-light FSM.
module traffic_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int GAP      = GAP_DEF,
  parameter int CW       = CNT_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sa_raw,
  input  logic          sb_raw,
  input  logic          clr_cnt,
  output logic          a,
  output logic          b,
  output logic [CW-1:0] a_cnt,
  output logic [CW-1:0] b_cnt
);

  sensor_channel #(
    .DEBOUNCE(DEBOUNCE),
    .GAP     (GAP),
    .CW      (CW)
  ) u_a (
    .clk    (clk),
    .reset  (reset),
    .raw    (sa_raw),
    .clr_cnt(clr_cnt),
    .present(a),
    .cnt    (a_cnt)
  );

  sensor_channel #(
    .DEBOUNCE(DEBOUNCE),
    .GAP     (GAP),
    .CW      (CW)
  ) u_b (
    .clk    (clk),
    .reset  (reset),
    .raw    (sb_raw),
    .clr_cnt(clr_cnt),
    .present(b),
    .cnt    (b_cnt)
  );

endmodule
